// File: rtl/jvs_node_info_pkg.sv
// Shared JVS node definitions: feature-check function codes, the latched
// capability record, and helpers that map a record slot to its payload bytes.
package jvs_node_info_pkg;

    localparam logic [7:0] JVS_CMD_FEATCHK  = 8'h14;

    localparam logic [7:0] JVS_FN_SWITCH    = 8'h01;
    localparam logic [7:0] JVS_FN_COIN      = 8'h02;
    localparam logic [7:0] JVS_FN_ANALOG    = 8'h03;
    localparam logic [7:0] JVS_FN_ROTARY    = 8'h04;
    localparam logic [7:0] JVS_FN_KEYCODE   = 8'h05;
    localparam logic [7:0] JVS_FN_SCREEN    = 8'h06;
    localparam logic [7:0] JVS_FN_MISC_SW   = 8'h07;
    localparam logic [7:0] JVS_FN_CARD      = 8'h10;
    localparam logic [7:0] JVS_FN_HOPPER    = 8'h11;
    localparam logic [7:0] JVS_FN_GPO       = 8'h12;
    localparam logic [7:0] JVS_FN_AOUT      = 8'h13;
    localparam logic [7:0] JVS_FN_CHARDISP  = 8'h14;
    localparam logic [7:0] JVS_FN_BACKUP    = 8'h15;

    localparam int unsigned JVS_FN_COUNT = 13;

    typedef enum logic [1:0] {
        FEAT_IDLE,
        FEAT_RPT,
        FEAT_REC,
        FEAT_TERM
    } jvs_feat_state_t;

    typedef struct packed {
        logic [3:0]  players;
        logic [7:0]  buttons;
        logic [3:0]  coin_slots;
        logic [3:0]  analog_ch;
        logic [7:0]  analog_bits;
        logic [3:0]  rotary_ch;
        logic        keycode;
        logic        scr_en;
        logic [7:0]  scr_xbits;
        logic [7:0]  scr_ybits;
        logic [7:0]  scr_ch;
        logic [15:0] misc_sw;
        logic [7:0]  card_slots;
        logic [7:0]  hopper_ch;
        logic [7:0]  gpo;
        logic [3:0]  aout_ch;
        logic        chr_en;
        logic [7:0]  chr_w;
        logic [7:0]  chr_h;
        logic [7:0]  chr_type;
        logic        backup;
    } jvs_feature_caps_t;

    // Bit i corresponds to record slot i in ascending function-code order.
    function automatic logic [12:0] feature_enables(input jvs_feature_caps_t c);
        logic [12:0] en;
        en[0]  = (c.players    != '0);
        en[1]  = (c.coin_slots != '0);
        en[2]  = (c.analog_ch  != '0);
        en[3]  = (c.rotary_ch  != '0);
        en[4]  = c.keycode;
        en[5]  = c.scr_en;
        en[6]  = (c.misc_sw    != '0);
        en[7]  = (c.card_slots != '0);
        en[8]  = (c.hopper_ch  != '0);
        en[9]  = (c.gpo        != '0);
        en[10] = (c.aout_ch    != '0);
        en[11] = c.chr_en;
        en[12] = c.backup;
        return en;
    endfunction

    function automatic logic [7:0] feature_code(input logic [3:0] idx);
        case (idx)
            4'd0:    return JVS_FN_SWITCH;
            4'd1:    return JVS_FN_COIN;
            4'd2:    return JVS_FN_ANALOG;
            4'd3:    return JVS_FN_ROTARY;
            4'd4:    return JVS_FN_KEYCODE;
            4'd5:    return JVS_FN_SCREEN;
            4'd6:    return JVS_FN_MISC_SW;
            4'd7:    return JVS_FN_CARD;
            4'd8:    return JVS_FN_HOPPER;
            4'd9:    return JVS_FN_GPO;
            4'd10:   return JVS_FN_AOUT;
            4'd11:   return JVS_FN_CHARDISP;
            4'd12:   return JVS_FN_BACKUP;
            default: return 8'h00;
        endcase
    endfunction

    // Byte pos of the 4-byte record in slot idx; pos 0 is the function code.
    function automatic logic [7:0] feature_byte(input jvs_feature_caps_t c,
                                                input logic [3:0] idx,
                                                input logic [1:0] pos);
        logic [7:0] p1;
        logic [7:0] p2;
        logic [7:0] p3;
        p1 = '0;
        p2 = '0;
        p3 = '0;
        case (idx)
            4'd0:  begin p1 = {4'h0, c.players};    p2 = c.buttons;     end
            4'd1:  p1 = {4'h0, c.coin_slots};
            4'd2:  begin p1 = {4'h0, c.analog_ch};  p2 = c.analog_bits; end
            4'd3:  p1 = {4'h0, c.rotary_ch};
            4'd5:  begin p1 = c.scr_xbits; p2 = c.scr_ybits; p3 = c.scr_ch; end
            4'd6:  begin p1 = c.misc_sw[15:8]; p2 = c.misc_sw[7:0];    end
            4'd7:  p1 = c.card_slots;
            4'd8:  p1 = c.hopper_ch;
            4'd9:  p1 = c.gpo;
            4'd10: p1 = {4'h0, c.aout_ch};
            4'd11: begin p1 = c.chr_w; p2 = c.chr_h; p3 = c.chr_type;  end
            default: ;
        endcase
        case (pos)
            2'd0:    return feature_code(idx);
            2'd1:    return p1;
            2'd2:    return p2;
            default: return p3;
        endcase
    endfunction

endpackage

// File: rtl/jvs_feature_rec_sel.sv
// Finds the lowest enabled record slot at or above base_idx so disabled
// records cost no bubble cycles in the payload stream.
module jvs_feature_rec_sel
    import jvs_node_info_pkg::*;
(
    input  logic [12:0] en,
    input  logic [4:0]  base_idx,
    output logic [3:0]  next_idx,
    output logic        found
);

    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < JVS_FN_COUNT; i++) begin
            if (!found && (5'(i) >= base_idx) && en[i]) begin
                found    = 1'b1;
                next_idx = 4'(i);
            end
        end
    end

endmodule

// File: rtl/jvs_feature_encoder.sv
// Node-side feature-check (0x14) payload serialiser: REPORT_OK, one 4-byte
// record per enabled capability in code order, then a 0x00 terminator.
module jvs_feature_encoder
    import jvs_node_info_pkg::*;
#(
    parameter logic [7:0] REPORT_OK = 8'h01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  cap_players,
    input  logic [7:0]  cap_buttons,
    input  logic [3:0]  cap_coin_slots,
    input  logic [3:0]  cap_analog_ch,
    input  logic [7:0]  cap_analog_bits,
    input  logic [3:0]  cap_rotary_ch,
    input  logic        cap_keycode,
    input  logic        cap_scr_en,
    input  logic [7:0]  cap_scr_xbits,
    input  logic [7:0]  cap_scr_ybits,
    input  logic [7:0]  cap_scr_ch,
    input  logic [15:0] cap_misc_sw,
    input  logic [7:0]  cap_card_slots,
    input  logic [7:0]  cap_hopper_ch,
    input  logic [7:0]  cap_gpo,
    input  logic [3:0]  cap_aout_ch,
    input  logic        cap_chr_en,
    input  logic [7:0]  cap_chr_w,
    input  logic [7:0]  cap_chr_h,
    input  logic [7:0]  cap_chr_type,
    input  logic        cap_backup,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        busy,
    output logic        done
);

    jvs_feat_state_t   state;
    jvs_feature_caps_t caps_in;
    jvs_feature_caps_t caps_q;
    logic [3:0]        idx;
    logic [1:0]        pos;
    logic [12:0]       en;
    logic [4:0]        base_idx;
    logic [3:0]        next_idx;
    logic              found;
    logic              xfer;

    always_comb begin
        caps_in.players     = cap_players;
        caps_in.buttons     = cap_buttons;
        caps_in.coin_slots  = cap_coin_slots;
        caps_in.analog_ch   = cap_analog_ch;
        caps_in.analog_bits = cap_analog_bits;
        caps_in.rotary_ch   = cap_rotary_ch;
        caps_in.keycode     = cap_keycode;
        caps_in.scr_en      = cap_scr_en;
        caps_in.scr_xbits   = cap_scr_xbits;
        caps_in.scr_ybits   = cap_scr_ybits;
        caps_in.scr_ch      = cap_scr_ch;
        caps_in.misc_sw     = cap_misc_sw;
        caps_in.card_slots  = cap_card_slots;
        caps_in.hopper_ch   = cap_hopper_ch;
        caps_in.gpo         = cap_gpo;
        caps_in.aout_ch     = cap_aout_ch;
        caps_in.chr_en      = cap_chr_en;
        caps_in.chr_w       = cap_chr_w;
        caps_in.chr_h       = cap_chr_h;
        caps_in.chr_type    = cap_chr_type;
        caps_in.backup      = cap_backup;
    end

    assign en       = feature_enables(caps_q);
    assign xfer     = m_valid & m_ready;
    // From REPORT_OK the search starts at slot 0; otherwise just past the current record.
    assign base_idx = (state == FEAT_RPT) ? 5'd0 : ({1'b0, idx} + 5'd1);

    jvs_feature_rec_sel u_rec_sel (
        .en       (en),
        .base_idx (base_idx),
        .next_idx (next_idx),
        .found    (found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FEAT_IDLE;
            caps_q  <= '0;
            idx     <= '0;
            pos     <= '0;
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                FEAT_IDLE: begin
                    if (start) begin
                        caps_q  <= caps_in;
                        state   <= FEAT_RPT;
                        busy    <= 1'b1;
                        m_valid <= 1'b1;
                        m_data  <= REPORT_OK;
                        m_last  <= 1'b0;
                    end
                end
                FEAT_RPT, FEAT_REC: begin
                    if (xfer) begin
                        if (state == FEAT_REC && pos != 2'd3) begin
                            pos    <= pos + 2'd1;
                            m_data <= feature_byte(caps_q, idx, pos + 2'd1);
                        end else if (found) begin
                            state  <= FEAT_REC;
                            idx    <= next_idx;
                            pos    <= '0;
                            m_data <= feature_code(next_idx);
                        end else begin
                            state  <= FEAT_TERM;
                            m_data <= '0;
                            m_last <= 1'b1;
                        end
                    end
                end
                FEAT_TERM: begin
                    if (xfer) begin
                        state   <= FEAT_IDLE;
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        m_data  <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: state <= FEAT_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jvs_feature_encoder.sv
// Randomised bench for jvs_feature_encoder against a byte-queue reference
// model built directly from the capability inputs.
module tb_jvs_feature_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  cap_players, cap_coin_slots, cap_analog_ch, cap_rotary_ch, cap_aout_ch;
    logic [7:0]  cap_buttons, cap_analog_bits, cap_scr_xbits, cap_scr_ybits, cap_scr_ch;
    logic [7:0]  cap_card_slots, cap_hopper_ch, cap_gpo, cap_chr_w, cap_chr_h, cap_chr_type;
    logic [15:0] cap_misc_sw;
    logic        cap_keycode, cap_scr_en, cap_chr_en, cap_backup;
    logic [7:0]  m_data;
    logic        m_valid, m_last, busy, done;
    logic        m_ready = 1'b0;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    jvs_feature_encoder #(.REPORT_OK(8'h01)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cap_players(cap_players), .cap_buttons(cap_buttons),
        .cap_coin_slots(cap_coin_slots), .cap_analog_ch(cap_analog_ch),
        .cap_analog_bits(cap_analog_bits), .cap_rotary_ch(cap_rotary_ch),
        .cap_keycode(cap_keycode), .cap_scr_en(cap_scr_en),
        .cap_scr_xbits(cap_scr_xbits), .cap_scr_ybits(cap_scr_ybits),
        .cap_scr_ch(cap_scr_ch), .cap_misc_sw(cap_misc_sw),
        .cap_card_slots(cap_card_slots), .cap_hopper_ch(cap_hopper_ch),
        .cap_gpo(cap_gpo), .cap_aout_ch(cap_aout_ch), .cap_chr_en(cap_chr_en),
        .cap_chr_w(cap_chr_w), .cap_chr_h(cap_chr_h), .cap_chr_type(cap_chr_type),
        .cap_backup(cap_backup),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .done(done)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_caps();
        {cap_players, cap_coin_slots, cap_analog_ch, cap_rotary_ch, cap_aout_ch} = '0;
        {cap_buttons, cap_analog_bits, cap_scr_xbits, cap_scr_ybits, cap_scr_ch} = '0;
        {cap_card_slots, cap_hopper_ch, cap_gpo, cap_chr_w, cap_chr_h, cap_chr_type} = '0;
        cap_misc_sw = '0;
        {cap_keycode, cap_scr_en, cap_chr_en, cap_backup} = '0;
    endtask

    // Each capability is zeroed about half the time unless force_on is set.
    task automatic random_caps(input bit force_on);
        cap_players     = (force_on || $urandom_range(1) == 1) ? 4'($urandom_range(15, 1)) : 4'h0;
        cap_buttons     = 8'($urandom);
        cap_coin_slots  = (force_on || $urandom_range(1) == 1) ? 4'($urandom_range(15, 1)) : 4'h0;
        cap_analog_ch   = (force_on || $urandom_range(1) == 1) ? 4'($urandom_range(15, 1)) : 4'h0;
        cap_analog_bits = 8'($urandom);
        cap_rotary_ch   = (force_on || $urandom_range(1) == 1) ? 4'($urandom_range(15, 1)) : 4'h0;
        cap_keycode     = force_on || ($urandom_range(1) == 1);
        cap_scr_en      = force_on || ($urandom_range(1) == 1);
        cap_scr_xbits   = 8'($urandom);
        cap_scr_ybits   = 8'($urandom);
        cap_scr_ch      = 8'($urandom);
        cap_misc_sw     = (force_on || $urandom_range(1) == 1) ? 16'($urandom_range(65535, 1)) : 16'h0;
        cap_card_slots  = (force_on || $urandom_range(1) == 1) ? 8'($urandom_range(255, 1)) : 8'h0;
        cap_hopper_ch   = (force_on || $urandom_range(1) == 1) ? 8'($urandom_range(255, 1)) : 8'h0;
        cap_gpo         = (force_on || $urandom_range(1) == 1) ? 8'($urandom_range(255, 1)) : 8'h0;
        cap_aout_ch     = (force_on || $urandom_range(1) == 1) ? 4'($urandom_range(15, 1)) : 4'h0;
        cap_chr_en      = force_on || ($urandom_range(1) == 1);
        cap_chr_w       = 8'($urandom);
        cap_chr_h       = 8'($urandom);
        cap_chr_type    = 8'($urandom);
        cap_backup      = force_on || ($urandom_range(1) == 1);
    endtask

    task automatic push_rec(input logic [7:0] code, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] c);
        exp_q.push_back(code);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
    endtask

    task automatic build_expected();
        exp_q.delete();
        exp_q.push_back(8'h01);
        if (cap_players != 0)    push_rec(8'h01, {4'h0, cap_players}, cap_buttons, 8'h00);
        if (cap_coin_slots != 0) push_rec(8'h02, {4'h0, cap_coin_slots}, 8'h00, 8'h00);
        if (cap_analog_ch != 0)  push_rec(8'h03, {4'h0, cap_analog_ch}, cap_analog_bits, 8'h00);
        if (cap_rotary_ch != 0)  push_rec(8'h04, {4'h0, cap_rotary_ch}, 8'h00, 8'h00);
        if (cap_keycode)         push_rec(8'h05, 8'h00, 8'h00, 8'h00);
        if (cap_scr_en)          push_rec(8'h06, cap_scr_xbits, cap_scr_ybits, cap_scr_ch);
        if (cap_misc_sw != 0)    push_rec(8'h07, cap_misc_sw[15:8], cap_misc_sw[7:0], 8'h00);
        if (cap_card_slots != 0) push_rec(8'h10, cap_card_slots, 8'h00, 8'h00);
        if (cap_hopper_ch != 0)  push_rec(8'h11, cap_hopper_ch, 8'h00, 8'h00);
        if (cap_gpo != 0)        push_rec(8'h12, cap_gpo, 8'h00, 8'h00);
        if (cap_aout_ch != 0)    push_rec(8'h13, {4'h0, cap_aout_ch}, 8'h00, 8'h00);
        if (cap_chr_en)          push_rec(8'h14, cap_chr_w, cap_chr_h, cap_chr_type);
        if (cap_backup)          push_rec(8'h15, 8'h00, 8'h00, 8'h00);
        exp_q.push_back(8'h00);
    endtask

    // Called at a negedge with the DUT idle. inject_at / abort_at < 0 disables them.
    task automatic run_stream(input int ready_pct, input int inject_at,
                              input int abort_at, input bit tight);
        int n, cyc, len;
        bit rdy, prev_stall, injected, aborted;
        logic [7:0] prev_data;
        logic prev_last;
        build_expected();
        len = exp_q.size();
        n = 0; cyc = 0; prev_stall = 0; injected = 0; aborted = 0;
        prev_data = '0; prev_last = 0;
        start = 1'b1;
        @(negedge clk);
        while (n < len && cyc < 1000) begin
            if (abort_at >= 0 && n == abort_at) begin
                aborted = 1;
                break;
            end
            check_eq("busy_during", 32'(busy), 32'd1);
            check_eq("valid_during", 32'(m_valid), 32'd1);
            if (prev_stall) begin
                check_eq("stall_data", 32'(m_data), 32'(prev_data));
                check_eq("stall_last", 32'(m_last), 32'(prev_last));
            end
            start = 1'b0;
            if (inject_at >= 0 && n == inject_at && !injected) begin
                random_caps(1'b0);
                start = 1'b1;
                injected = 1;
            end
            rdy = ($urandom_range(99) < ready_pct);
            m_ready = rdy;
            if (rdy && m_valid) begin
                check_eq($sformatf("byte%0d", n), 32'(m_data), 32'(exp_q[n]));
                check_eq($sformatf("last%0d", n), 32'(m_last), 32'(n == len - 1));
                n++;
            end
            prev_stall = m_valid && !rdy;
            prev_data = m_data;
            prev_last = m_last;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        m_ready = 1'b0;
        if (aborted) begin
            rst_n = 1'b0;
            #1;
            check_eq("rst_valid", 32'(m_valid), 32'd0);
            check_eq("rst_data", 32'(m_data), 32'd0);
            check_eq("rst_last", 32'(m_last), 32'd0);
            check_eq("rst_busy", 32'(busy), 32'd0);
            check_eq("rst_done", 32'(done), 32'd0);
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            m_ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check_eq("post_rst_done", 32'(done), 32'd0);
                check_eq("post_rst_valid", 32'(m_valid), 32'd0);
            end
            m_ready = 1'b0;
            return;
        end
        check_eq("stream_complete", 32'(n), 32'(len));
        if (tight) check_eq("stream_cycles", 32'(cyc), 32'(len));
        check_eq("done_pulse", 32'(done), 32'd1);
        check_eq("busy_after", 32'(busy), 32'd0);
        check_eq("valid_after", 32'(m_valid), 32'd0);
        check_eq("last_after", 32'(m_last), 32'd0);
        @(negedge clk);
        check_eq("done_clear", 32'(done), 32'd0);
        check_eq("no_restart", 32'(m_valid), 32'd0);
    endtask

    initial begin
        clear_caps();
        repeat (3) @(negedge clk);
        check_eq("reset_data", 32'(m_data), 32'd0);
        check_eq("reset_valid", 32'(m_valid), 32'd0);
        check_eq("reset_last", 32'(m_last), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_stream(100, -1, -1, 1'b1);

        clear_caps();
        cap_players = 4'd2; cap_buttons = 8'd13; cap_coin_slots = 4'd2;
        cap_analog_ch = 4'd8; cap_analog_bits = 8'd10;
        run_stream(100, -1, -1, 1'b1);

        clear_caps();
        cap_misc_sw = 16'h0123; cap_gpo = 8'd6;
        run_stream(100, -1, -1, 1'b1);

        random_caps(1'b1);
        run_stream(50, -1, -1, 1'b0);

        random_caps(1'b1);
        run_stream(70, 7, -1, 1'b0);

        random_caps(1'b1);
        run_stream(100, -1, 5, 1'b0);
        run_stream(100, -1, -1, 1'b1);

        for (int k = 0; k < 20; k++) begin
            random_caps(1'b0);
            run_stream(60, (k % 4 == 0) ? 3 : -1, -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jvs_feature_encoder.md
Name: jvs_feature_encoder

Overview:
- Serialises a JVS I/O node's capability set into the byte payload of the feature-check (command 0x14) response.
- This is the node side of the feature-check exchange; the host side decodes the same payload into jvs_node_info_t.
- Sits in the JVS node-emulation path, between a capability config source and the frame/checksum transmitter, which consumes bytes via valid/ready.

Parameters:
- REPORT_OK, 8'h01, report byte emitted before the first function record.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches all cap_* inputs and begins a response. Ignored while busy.
- cap_players  in  4  switch-input players; 0 disables record 0x01.
- cap_buttons  in  8  buttons per player.
- cap_coin_slots  in  4  coin slots; 0 disables record 0x02.
- cap_analog_ch  in  4  analog channels; 0 disables record 0x03.
- cap_analog_bits  in  8  analog resolution.
- cap_rotary_ch  in  4  rotary channels; 0 disables record 0x04.
- cap_keycode  in  1  enables record 0x05.
- cap_scr_en  in  1  enables record 0x06.
- cap_scr_xbits  in  8  screen X bits.
- cap_scr_ybits  in  8  screen Y bits.
- cap_scr_ch  in  8  screen-position channels.
- cap_misc_sw  in  16  misc switch bits; 0 disables record 0x07.
- cap_card_slots  in  8  0 disables record 0x10.
- cap_hopper_ch  in  8  0 disables record 0x11.
- cap_gpo  in  8  general-purpose output count; 0 disables record 0x12.
- cap_aout_ch  in  4  analog output channels; 0 disables record 0x13.
- cap_chr_en  in  1  enables record 0x14.
- cap_chr_w  in  8  character display width.
- cap_chr_h  in  8  character display height.
- cap_chr_type  in  8  character display type.
- cap_backup  in  1  enables record 0x15.
- m_data  out  8  payload byte.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accepts byte.
- m_last  out  1  high with the terminating 0x00 byte.
- busy  out  1  high from the cycle after start until the last byte transfers.
- done  out  1  one-cycle pulse on the cycle after the last byte transfer.

Behaviour:
- Reset: m_data=0, m_valid=0, m_last=0, busy=0, done=0; FSM=IDLE; latched caps cleared.
- FSM states: IDLE -> RPT -> REC -> TERM -> IDLE.
- IDLE: a start pulse latches the caps; next cycle the FSM enters RPT with busy=1, m_valid=1, m_data=REPORT_OK.
- Transfer rule: a byte transfers when m_valid and m_ready are both high. m_data and m_last stay stable while m_valid=1 and m_ready=0.
- Byte stream: after REPORT_OK, emit each enabled record in ascending code order. Order: 01,02,03,04,05,06,07,10,11,12,13,14,15.
- Each record is 4 bytes: code, p1, p2, p3.
  - 01: players, buttons, 0.
  - 02: slots, 0, 0.
  - 03: channels, bits, 0.
  - 04: channels, 0, 0.
  - 05: 0, 0, 0.
  - 06: xbits, ybits, channels.
  - 07: misc[15:8], misc[7:0], 0.
  - 10: slots, 0, 0.
  - 11: channels, 0, 0.
  - 12: count, 0, 0.
  - 13: channels, 0, 0.
  - 14: width, height, type.
  - 15: 0, 0, 0.
- 4-bit caps are zero-extended to 8 bits.
- Disabled records are skipped with zero bubble cycles: the next enabled record index is found combinationally from the current index.
- When no further record is enabled, enter TERM and emit 0x00 with m_last=1. On its transfer: busy=0, m_valid=0, done=1 for one cycle, FSM=IDLE.
- Throughput: one byte per cycle while m_ready=1. Length = 2 + 4*N (N = enabled records, 0..13); max 54 bytes.
- start while busy: ignored; latched caps are unchanged.
- cap_* changes while busy: no effect.
- rst_n low mid-response: outputs return to reset values immediately; no partial byte or done pulse follows.

Decomposition:
- Shared package jvs_node_info_pkg gains localparam function codes: JVS_FN_SWITCH=8'h01 ... JVS_FN_BACKUP=8'h15.
- It also gains JVS_CMD_FEATCHK=8'h14 and typedef struct jvs_feature_caps_t, which holds the latch.
- Sub-module jvs_feature_rec_sel: combinational. Given the enable vector [12:0] and the current index, it returns next_idx and found.

Test Plan:
- All caps 0 -> exactly 01,00; m_last on 2nd byte; done one cycle after.
- players=2, buttons=13, coin=2, analog_ch=8, bits=10, m_ready=1 -> 01,01,02,0D,00,02,02,00,00,03,08,0A,00,00 in 14 consecutive cycles.
- misc_sw=16'h0123, gpo=6 -> 01,07,01,23,00,12,06,00,00,00.
- Every record enabled, random m_ready (~50%) -> 54 bytes in code order; m_data is held stable during every stall.
- start mid-response with altered caps -> current stream unchanged; no restart until done.
- rst_n asserted after byte 5, then a fresh start -> stream restarts from 01 with no residue and no spurious done.
